// File: rtl/float_div.sv
// Sequential IEEE-754 binary32 divider (z = a / b): restoring radix-2 mantissa divide,
// round-to-nearest-even, denormal operands and results flushed to zero.
module float_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] z
);

  typedef enum logic [2:0] {StIdle, StUnpack, StDivide, StNorm, StRound} state_e;

  state_e             r_state;
  logic [31:0]        r_a, r_b, r_z;
  logic               r_s, r_done, r_g, r_st;
  logic signed [9:0]  r_e;
  logic [23:0]        r_mb, r_mant;
  logic [24:0]        r_rem;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;

  logic               w_s;
  logic               w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
  logic               w_special;
  logic [31:0]        w_special_z;
  logic signed [9:0]  w_e_unp;
  logic               w_ge;
  logic [24:0]        w_rem_nx;
  logic               w_inc;
  logic [24:0]        w_sum;
  logic [23:0]        w_mant_r;
  logic signed [9:0]  w_e_r;
  logic [31:0]        w_packed;

  assign busy = (r_state != StIdle);
  assign done = r_done;
  assign z    = r_z;

  assign w_s      = r_a[31] ^ r_b[31];
  assign w_a_zero = (r_a[30:23] == 8'h00);
  assign w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'h0);
  assign w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'h0);
  assign w_b_zero = (r_b[30:23] == 8'h00);
  assign w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'h0);
  assign w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'h0);
  assign w_e_unp  = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]}) + 10'sd127;

  always_comb begin
    w_special   = 1'b1;
    w_special_z = 32'h0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_special_z = 32'h7FC0_0000;
    end else if (w_a_inf || w_b_zero) begin
      w_special_z = {w_s, 8'hFF, 23'h0};
    end else if (w_a_zero || w_b_inf) begin
      w_special_z = {w_s, 31'h0};
    end else begin
      w_special = 1'b0;
    end
  end

  // Remainder stays below 2*mb, so the shifted value always fits 25 bits.
  assign w_ge     = (r_rem >= {1'b0, r_mb});
  assign w_rem_nx = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  assign w_inc    = r_g & (r_st | r_mant[0]);
  assign w_sum    = {1'b0, r_mant} + {24'h0, w_inc};
  assign w_mant_r = w_sum[24] ? w_sum[24:1] : w_sum[23:0];
  assign w_e_r    = r_e + (w_sum[24] ? 10'sd1 : 10'sd0);

  always_comb begin
    if (w_e_r >= 10'sd255) begin
      w_packed = {r_s, 8'hFF, 23'h0};
    end else if (w_e_r <= 10'sd0) begin
      w_packed = {r_s, 31'h0};
    end else begin
      w_packed = {r_s, w_e_r[7:0], w_mant_r[22:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_z     <= 32'h0;
      r_done  <= 1'b0;
      r_s     <= 1'b0;
      r_e     <= 10'sd0;
      r_mb    <= 24'h0;
      r_rem   <= 25'h0;
      r_q     <= 26'h0;
      r_cnt   <= 5'd0;
      r_mant  <= 24'h0;
      r_g     <= 1'b0;
      r_st    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_state <= StUnpack;
          end
        end
        StUnpack: begin
          r_s   <= w_s;
          r_e   <= w_e_unp;
          r_mb  <= {1'b1, r_b[22:0]};
          r_rem <= {2'b01, r_a[22:0]};
          r_q   <= 26'h0;
          r_cnt <= 5'd0;
          if (w_special) begin
            r_z     <= w_special_z;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_state <= StDivide;
          end
        end
        StDivide: begin
          r_rem <= w_rem_nx << 1;
          r_q   <= {r_q[24:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd25) r_state <= StNorm;
        end
        StNorm: begin
          if (r_q[25]) begin
            r_mant <= r_q[25:2];
            r_g    <= r_q[1];
            r_st   <= r_q[0] | (|r_rem);
          end else begin
            r_mant <= r_q[24:1];
            r_g    <= r_q[0];
            r_st   <= |r_rem;
            r_e    <= r_e - 10'sd1;
          end
          r_state <= StRound;
        end
        StRound: begin
          r_z     <= w_packed;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_float_div.sv
// Bench for float_div: directed corner cases plus random operands checked against an
// integer-arithmetic reference of the binary32 divide rules.
module tb_float_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] z;

  int n_total = 0;
  int n_bad   = 0;

  float_div u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: exact quotient of the significands via 64-bit integer division.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r_z, output int lat);
    int ex, ey, e;
    logic s, g, st;
    logic xz, xi, xn, yz, yi, yn;
    longint unsigned mx, my, q, rm, mant;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    xi = (ex == 255) && (x[22:0] == 23'h0);
    xn = (ex == 255) && (x[22:0] != 23'h0);
    yz = (ey == 0);
    yi = (ey == 255) && (y[22:0] == 23'h0);
    yn = (ey == 255) && (y[22:0] != 23'h0);
    lat = 1;
    if (xn || yn || (xz && yz) || (xi && yi)) begin r_z = 32'h7FC0_0000; return; end
    if (xi || yz) begin r_z = {s, 8'hFF, 23'h0}; return; end
    if (xz || yi) begin r_z = {s, 31'h0}; return; end
    lat = 29;
    mx = 64'(x[22:0]) + 64'h80_0000;
    my = 64'(y[22:0]) + 64'h80_0000;
    q  = (mx << 25) / my;
    rm = (mx << 25) % my;
    e  = ex - ey + 127;
    if (q >= 64'h200_0000) begin
      mant = q >> 2;
      g    = q[1];
      st   = q[0] | (rm != 0);
    end else begin
      mant = q >> 1;
      g    = q[0];
      st   = (rm != 0);
      e    = e - 1;
    end
    if (g && (st || mant[0])) mant = mant + 1;
    if (mant == 64'h100_0000) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255)    r_z = {s, 8'hFF, 23'h0};
    else if (e <= 0) r_z = {s, 31'h0};
    else             r_z = {s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int kind;
    logic [31:0] v;
    kind = $urandom_range(0, 19);
    v = $urandom;
    case (kind)
      0:       v[30:23] = 8'h00;
      1:       begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
      2:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  // Accepting edge follows; inputs scrambled afterwards to show they are not used.
  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    check("done_pulse_low", {31'h0, done}, 32'h0);
  endtask

  task automatic wait_done(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input int poke_at);
    logic [31:0] exp_z;
    int exp_lat, cyc;
    ref_div(x, y, exp_z, exp_lat);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == poke_at) begin
        start = 1'b1;
        a     = 32'h4000_0000;
        b     = 32'h3F80_0000;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = i;
      if (done) break;
      check({tag, "_busy"}, {31'h0, busy}, 32'h1);
    end
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_z"}, z, exp_z);
    check({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
    launch(x, y);
    wait_done(tag, x, y, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_z", z, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("half",      32'h3F80_0000, 32'h4000_0000);
    check("half_val",   z, 32'h3F00_0000);
    run_op("six_1p5",   32'h40C0_0000, 32'h3FC0_0000);
    check("six_val",    z, 32'h4080_0000);
    run_op("third",     32'h3F80_0000, 32'h4040_0000);
    check("third_val",  z, 32'h3EAA_AAAB);
    run_op("div0",      32'hBF80_0000, 32'h0000_0000);
    check("div0_val",   z, 32'hFF80_0000);
    run_op("zz",        32'h0000_0000, 32'h0000_0000);
    run_op("infinf",    32'h7F80_0000, 32'h7F80_0000);
    run_op("nan",       32'h7FC0_0000, 32'h3E00_0000);
    run_op("inf_a",     32'h7F80_0000, 32'h4000_0000);
    check("inf_a_val",  z, 32'h7F80_0000);
    run_op("zero_a",    32'h0000_0000, 32'h4000_0000);
    run_op("ovf",       32'h7F00_0000, 32'h3E80_0000);
    check("ovf_val",    z, 32'h7F80_0000);
    run_op("unf",       32'h0080_0000, 32'h4000_0000);
    check("unf_val",    z, 32'h0000_0000);

    // Start while busy is ignored; start in the done cycle is accepted.
    launch(32'h4120_0000, 32'h4040_0000);
    wait_done("busy_ign", 32'h4120_0000, 32'h4040_0000, 5);
    launch(32'hC2C8_0000, 32'h40E0_0000);
    wait_done("b2b", 32'hC2C8_0000, 32'h40E0_0000, 0);

    // Asynchronous reset mid-divide.
    launch(32'h3F80_0000, 32'h4040_0000);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_z", z, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 32'h40A0_0000, 32'h4040_0000);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] x, y;
      x = rand_op();
      y = rand_op();
      run_op("rand", x, y);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
